// File: rtl/yutorina_bus_timer_pkg.sv
// yutorina_bus_timer_pkg -- shared definitions for the yutorina bus timer.
//   Bus widths, register indices, CTRL field layout, bus FSM state
//   encoding and helpers that format the register fields for read-back.
package yutorina_bus_timer_pkg;

  // Bus widths
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  // Register indices (word address low bits)
  localparam logic [ADDR_W-1:0] REG_CTRL    = 2'd0;
  localparam logic [ADDR_W-1:0] REG_INTR    = 2'd1;
  localparam logic [ADDR_W-1:0] REG_EXPR    = 2'd2;
  localparam logic [ADDR_W-1:0] REG_COUNTER = 2'd3;

  // Bus handshake FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_e;

  // CTRL layout: bit1 periodic, bit0 start
  typedef struct packed {
    logic periodic;
    logic start;
  } ctrl_t;

  // CTRL as a bus word; bits above the two fields read as zero
  function automatic logic [DATA_W-1:0] ctrl_word(input ctrl_t c);
    return {{(DATA_W-2){1'b0}}, c};
  endfunction

  // INTR as a bus word; only the flag bit is implemented
  function automatic logic [DATA_W-1:0] flag_word(input logic f);
    return {{(DATA_W-1){1'b0}}, f};
  endfunction

endpackage

// File: rtl/yutorina_bus_timer.sv
// yutorina_bus_timer -- memory-mapped interval timer with a fixed-latency
// asynchronous-style bus handshake.
//
// Ports:
//   clk     sole clock, rising edge
//   rst     synchronous reset, active-low
//   cs_     chip select from the address decoder, active-low
//   as_     address strobe from the bus master, active-low
//   rw      access direction, 1 = read, 0 = write
//   addr    register index: 0 CTRL, 1 INTR, 2 EXPR, 3 COUNTER
//   w_data  write data
//   r_data  read data, valid only while rdy_ is low, otherwise 0
//   rdy_    access-complete strobe, active-low, one cycle per access
//   irq     level interrupt, mirrors INTR.flag
//
// Every access takes exactly two cycles from strobe to rdy_: the strobe
// cycle is latched, the ACCESS cycle performs the write or samples the
// read value, and DONE presents rdy_/r_data. Strobes seen outside IDLE are
// ignored, so a strobe held low restarts an access every third cycle.
module yutorina_bus_timer
  import yutorina_bus_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              rdy_,
  output logic              irq
);

  // Bus FSM and latched request
  bus_state_e        state_r;
  bus_state_e        state_nxt_s;
  logic              latch_s;
  logic              rw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] w_data_r;

  // Registered bus outputs
  logic              rdy_r;
  logic              rdy_nxt_s;
  logic [DATA_W-1:0] r_data_r;
  logic [DATA_W-1:0] r_data_nxt_s;

  // Access decode
  logic              strobe_s;
  logic              access_s;
  logic              wr_s;
  logic              wr_ctrl_s;
  logic              wr_intr_s;
  logic              wr_expr_s;
  logic              wr_counter_s;
  logic [DATA_W-1:0] rd_word_s;

  // Timer registers
  ctrl_t             ctrl_r;
  ctrl_t             ctrl_nxt_s;
  logic              flag_r;
  logic              flag_nxt_s;
  logic [DATA_W-1:0] expr_r;
  logic [DATA_W-1:0] expr_nxt_s;
  logic [DATA_W-1:0] counter_r;
  logic [DATA_W-1:0] counter_nxt_s;
  logic              expire_s;
  logic              count_s;

  assign strobe_s = ~cs_ & ~as_;

  // The register work of an access happens only in ACCESS and only with the
  // fields captured on the strobe, so bus inputs may change freely afterwards.
  assign access_s     = (state_r == ST_ACCESS);
  assign wr_s         = access_s & ~rw_r;
  assign wr_ctrl_s    = wr_s & (addr_r == REG_CTRL);
  assign wr_intr_s    = wr_s & (addr_r == REG_INTR);
  assign wr_expr_s    = wr_s & (addr_r == REG_EXPR);
  assign wr_counter_s = wr_s & (addr_r == REG_COUNTER);

  // Read-back mux over the pre-update register values
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    case (addr_r)
      REG_CTRL:    rd_word_s = ctrl_word(ctrl_r);
      REG_INTR:    rd_word_s = flag_word(flag_r);
      REG_EXPR:    rd_word_s = expr_r;
      REG_COUNTER: rd_word_s = counter_r;
      default:     rd_word_s = {DATA_W{1'b0}};
    endcase
  end

  // Bus FSM next state and next values of the registered outputs
  always_comb begin
    state_nxt_s  = state_r;
    latch_s      = 1'b0;
    rdy_nxt_s    = 1'b1;
    r_data_nxt_s = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (strobe_s) begin
          state_nxt_s = ST_ACCESS;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // rdy_ and r_data are registered, so they are set up here and
        // appear during DONE.
        state_nxt_s = ST_DONE;
        rdy_nxt_s   = 1'b0;
        if (rw_r) begin
          r_data_nxt_s = rd_word_s;
        end else begin
          r_data_nxt_s = {DATA_W{1'b0}};
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus FSM state, request latch and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      rw_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      w_data_r <= {DATA_W{1'b0}};
      rdy_r    <= 1'b1;
      r_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      rdy_r    <= rdy_nxt_s;
      r_data_r <= r_data_nxt_s;
      if (latch_s) begin
        rw_r     <= rw;
        addr_r   <= addr;
        w_data_r <= w_data;
      end
    end
  end

  // Expiry compares against the current EXPR; a write to EXPR in the same
  // cycle only affects later comparisons.
  assign expire_s = ctrl_r.start & (counter_r == expr_r);
  assign count_s  = ctrl_r.start & (counter_r != expr_r);

  // Timer next values: a bus write to a register overrides whatever the
  // counting logic would have done to that same register this cycle.
  always_comb begin
    ctrl_nxt_s    = ctrl_r;
    flag_nxt_s    = flag_r;
    expr_nxt_s    = expr_r;
    counter_nxt_s = counter_r;

    if (wr_ctrl_s) begin
      ctrl_nxt_s = ctrl_t'(w_data_r[1:0]);
    end else if (expire_s && !ctrl_r.periodic) begin
      ctrl_nxt_s.start = 1'b0;
    end else begin
      ctrl_nxt_s = ctrl_r;
    end

    // Software clear of the flag beats a simultaneous expiry
    if (wr_intr_s) begin
      flag_nxt_s = w_data_r[0];
    end else if (expire_s) begin
      flag_nxt_s = 1'b1;
    end else begin
      flag_nxt_s = flag_r;
    end

    if (wr_expr_s) begin
      expr_nxt_s = w_data_r;
    end else begin
      expr_nxt_s = expr_r;
    end

    // An EXPR below COUNTER is reached by natural 32-bit wrap-around
    if (wr_counter_s) begin
      counter_nxt_s = w_data_r;
    end else if (expire_s) begin
      counter_nxt_s = {DATA_W{1'b0}};
    end else if (count_s) begin
      counter_nxt_s = counter_r + 32'd1;
    end else begin
      counter_nxt_s = counter_r;
    end
  end

  // Timer register update
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_r    <= ctrl_t'(2'b00);
      flag_r    <= 1'b0;
      expr_r    <= {DATA_W{1'b0}};
      counter_r <= {DATA_W{1'b0}};
    end else begin
      ctrl_r    <= ctrl_nxt_s;
      flag_r    <= flag_nxt_s;
      expr_r    <= expr_nxt_s;
      counter_r <= counter_nxt_s;
    end
  end

  assign r_data = r_data_r;
  assign rdy_   = rdy_r;
  assign irq    = flag_r;

endmodule

// File: tb/tb_yutorina_bus_timer.sv
// tb_yutorina_bus_timer -- self-checking bench for yutorina_bus_timer.
// A behavioural model (register values plus the cycle number of the last
// accepted access) predicts rdy_, r_data and irq every cycle; directed
// scenarios add hand-computed literal expectations, then randomized
// per-cycle bus traffic with occasional resets runs against the model.
module tb_yutorina_bus_timer;

  logic        clk;
  logic        rst;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        rdy_;
  logic        irq;

  int n_vec;
  int n_mis;

  // Model state
  logic        m_start;
  logic        m_per;
  logic        m_flag;
  logic [31:0] m_expr;
  logic [31:0] m_cnt;
  int          cyc;
  int          acc_cyc;
  logic        a_rw;
  logic [1:0]  a_addr;
  logic [31:0] a_wdata;
  logic        exp_rdy;
  logic [31:0] exp_rdata;

  yutorina_bus_timer dut (
    .clk    (clk),
    .rst    (rst),
    .cs_    (cs_),
    .as_    (as_),
    .rw     (rw),
    .addr   (addr),
    .w_data (w_data),
    .r_data (r_data),
    .rdy_   (rdy_),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one clock edge. An access accepted at the end of cycle k works
  // on the registers at the end of cycle k+1 and completes in cycle k+2;
  // strobes are only accepted once that window has passed.
  task automatic model_edge();
    logic        hit;
    logic        n_start;
    logic        n_per;
    logic        n_flag;
    logic [31:0] n_expr;
    logic [31:0] n_cnt;
    if (!rst) begin
      m_start   = 1'b0;
      m_per     = 1'b0;
      m_flag    = 1'b0;
      m_expr    = 32'h0;
      m_cnt     = 32'h0;
      acc_cyc   = -100;
      exp_rdy   = 1'b1;
      exp_rdata = 32'h0;
    end else begin
      hit     = m_start && (m_cnt == m_expr);
      n_cnt   = !m_start ? m_cnt : (hit ? 32'h0 : m_cnt + 32'd1);
      n_start = m_start && !(hit && !m_per);
      n_per   = m_per;
      n_flag  = m_flag | hit;
      n_expr  = m_expr;
      exp_rdy   = 1'b1;
      exp_rdata = 32'h0;
      if (cyc == acc_cyc + 1) begin
        exp_rdy = 1'b0;
        if (a_rw) begin
          case (a_addr)
            2'd0:    exp_rdata = {30'h0, m_per, m_start};
            2'd1:    exp_rdata = {31'h0, m_flag};
            2'd2:    exp_rdata = m_expr;
            default: exp_rdata = m_cnt;
          endcase
        end else begin
          case (a_addr)
            2'd0:    begin n_per = a_wdata[1]; n_start = a_wdata[0]; end
            2'd1:    n_flag = a_wdata[0];
            2'd2:    n_expr = a_wdata;
            default: n_cnt = a_wdata;
          endcase
        end
      end
      if (!cs_ && !as_ && (cyc > acc_cyc + 2)) begin
        acc_cyc = cyc;
        a_rw    = rw;
        a_addr  = addr;
        a_wdata = w_data;
      end
      m_start = n_start;
      m_per   = n_per;
      m_flag  = n_flag;
      m_expr  = n_expr;
      m_cnt   = n_cnt;
    end
    cyc++;
  endtask

  // One clock: update the model at the edge, compare half a cycle later
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rdy_",   {31'h0, rdy_}, {31'h0, exp_rdy});
    chk("r_data", r_data, exp_rdata);
    chk("irq",    {31'h0, irq},  {31'h0, m_flag});
  endtask

  // One access; returns in the cycle where rdy_ is low
  task automatic bus_xfer(input logic x_rw, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int lat;
    cs_ = 1'b0; as_ = 1'b0; rw = x_rw; addr = a; w_data = d;
    step();
    cs_ = 1'b1; as_ = 1'b1;
    lat = 1;
    while (rdy_ !== 1'b0 && lat < 10) begin
      step();
      lat++;
    end
    chk("xfer_latency", 32'(lat), 32'd2);
    rd = r_data;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus_xfer(1'b0, a, d, v);
    step();
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    bus_xfer(1'b1, a, 32'h0, v);
    step();
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [31:0] v;
    int          n;
    n_vec = 0; n_mis = 0; cyc = 0; acc_cyc = -100;
    m_start = 1'b0; m_per = 1'b0; m_flag = 1'b0; m_expr = 32'h0; m_cnt = 32'h0;
    a_rw = 1'b0; a_addr = 2'd0; a_wdata = 32'h0; exp_rdy = 1'b1; exp_rdata = 32'h0;
    rst = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = 2'd0; w_data = 32'h0;

    // Reset state and read-back of all registers
    step();
    step();
    chk("rst_rdy", {31'h0, rdy_}, 32'h1);
    chk("rst_irq", {31'h0, irq},  32'h0);
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      chk("rst_read", v, 32'h0);
    end

    // One-shot: EXPR = 5, start
    wr_reg(2'd2, 32'd5);
    bus_xfer(1'b0, 2'd0, 32'h1, v);
    wait_irq(n);
    chk("oneshot_irq_delay", 32'(n), 32'd6);
    step();
    rd_reg(2'd3, v);
    chk("oneshot_counter", v, 32'h0);
    rd_reg(2'd0, v);
    chk("oneshot_ctrl", v, 32'h0);
    rd_reg(2'd1, v);
    chk("oneshot_intr", v, 32'h1);
    bus_xfer(1'b0, 2'd1, 32'h0, v);
    chk("intr_clear_irq", {31'h0, irq}, 32'h0);
    step();

    // Periodic: EXPR = 3, CTRL = 3
    wr_reg(2'd2, 32'd3);
    bus_xfer(1'b0, 2'd0, 32'h3, v);
    wait_irq(n);
    chk("periodic_first", 32'(n), 32'd4);
    step();
    rd_reg(2'd0, v);
    chk("periodic_ctrl", v, 32'h3);
    bus_xfer(1'b0, 2'd1, 32'h0, v);
    chk("periodic_clear_irq", {31'h0, irq}, 32'h0);
    wait_irq(n);
    chk("periodic_gap", {31'h0, (n >= 1 && n <= 4)}, 32'h1);
    step();
    wr_reg(2'd0, 32'h0);
    wr_reg(2'd1, 32'h0);

    // Strobe held low for five cycles: rdy_ in cycles 2 and 5 only
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd2; w_data = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("hold_rdy", {31'h0, rdy_}, (i == 2 || i == 5) ? 32'h0 : 32'h1);
      if (i == 2 || i == 5) begin
        chk("hold_rdata", r_data, 32'd3);
      end
    end
    cs_ = 1'b1; as_ = 1'b1;
    step();

    // Counter wrap: COUNTER = 0xFFFFFFFE, EXPR = 1, start
    wr_reg(2'd3, 32'hFFFF_FFFE);
    wr_reg(2'd2, 32'd1);
    bus_xfer(1'b0, 2'd0, 32'h1, v);
    wait_irq(n);
    chk("wrap_irq_delay", 32'(n), 32'd4);
    step();
    rd_reg(2'd3, v);
    chk("wrap_counter", v, 32'h0);
    wr_reg(2'd1, 32'h0);

    // Reset during ACCESS: no rdy_ pulse, write abandoned
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 2'd2; w_data = 32'd7;
    step();
    cs_ = 1'b1; as_ = 1'b1; rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_rdy", {31'h0, rdy_}, 32'h1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      chk("abort_read", v, 32'h0);
    end

    // Randomized traffic with small values so expiries are frequent
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) != 0);
      cs_    = $urandom_range(0, 1) == 0;
      as_    = $urandom_range(0, 1) == 0;
      rw     = 1'($urandom_range(0, 1));
      addr   = 2'($urandom_range(0, 3));
      w_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 9));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/yutorina_bus_timer.md
YUTORINA_BUS_TIMER -- requirements
Module: yutorina_bus_timer

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: cs_  in  1  chip select from bus address decoder, active-low.
REQ-004 SHALL have port: as_  in  1  address strobe from bus master, active-low.
REQ-005 SHALL have port: rw  in  1  access direction, 1 = read, 0 = write.
REQ-006 SHALL have port: addr  in  2  register index (word address low bits).
REQ-007 SHALL have port: w_data  in  32  write data.
REQ-008 SHALL have port: r_data  out  32  read data, valid only while rdy_ low, else 0.
REQ-009 SHALL have port: rdy_  out  1  access-complete strobe to master, active-low.
REQ-010 SHALL have port: irq  out  1  interrupt request, active-high, level.

Function
REQ-011 SHALL map registers: 0 CTRL {bit1 periodic, bit0 start}, 1 INTR {bit0 flag}, 2 EXPR expiry value, 3 COUNTER; unused CTRL/INTR bits read 0.
REQ-012 SHALL use FSM states IDLE, ACCESS, DONE.
REQ-013 SHALL move IDLE->ACCESS on a cycle with cs_ and as_ both low, latching rw, addr and w_data.
REQ-014 SHALL move ACCESS->DONE unconditionally; DONE drives rdy_ low for exactly one cycle, then returns to IDLE: fixed latency 2 cycles from strobe to rdy_.
REQ-015 SHALL ignore cs_/as_ while in ACCESS or DONE; a strobe held through DONE starts a new access only after returning to IDLE.
REQ-016 SHALL perform latched writes in the ACCESS cycle; reads return the register value as of the ACCESS cycle, presented on r_data in DONE.
REQ-017 SHALL increment COUNTER by 1 each cycle while CTRL.start = 1 and COUNTER != EXPR.
REQ-018 SHALL, when CTRL.start = 1 and COUNTER == EXPR: set INTR.flag, load COUNTER with 0, and clear CTRL.start unless CTRL.periodic = 1.
REQ-019 SHALL drive irq equal to INTR.flag.
REQ-020 SHALL give a bus write priority over counter update in the same cycle (write to COUNTER or CTRL wins over increment, expiry clear or start clear).
REQ-021 SHALL, on simultaneous expiry and write of INTR, store the written flag value (software clear wins).
REQ-022 SHALL wrap COUNTER from 0xFFFFFFFF to 0 when EXPR is below the current COUNTER value; no error flagged.
REQ-023 SHALL hold COUNTER unchanged while CTRL.start = 0.

Reset
REQ-024 SHALL, with rst low at a clock edge, set FSM to IDLE and zero CTRL, INTR, EXPR and COUNTER; outputs: rdy_ = 1, r_data = 0, irq = 0.
REQ-025 SHALL abandon an access in progress at reset with no rdy_ pulse and no register update.

Structure
REQ-026 SHALL take register indices, CTRL bit positions, FSM state encodings and bus widths from a shared header (timer.h) alongside the existing nettype and stddef headers.
REQ-027 SHALL be a single module with no sub-module; the bus FSM and counter are separate always blocks in one file.

Verification
REQ-028 SHALL cover: reset -> rdy_ = 1, irq = 0, reads of all four registers return 0.
REQ-029 SHALL cover: write EXPR = 5, write CTRL = 0x1 -> irq rises 6 cycles after the CTRL write completes, COUNTER = 0, CTRL reads 0x0.
REQ-030 SHALL cover: EXPR = 3, CTRL = 0x3 -> irq set every 4 cycles, CTRL stays 0x3; write INTR = 0 -> irq low next cycle.
REQ-031 SHALL cover: cs_ = 0, as_ = 0 held for 5 cycles -> rdy_ low on cycles 2 and 5 only, the second access correctly serviced.
REQ-032 SHALL cover: write COUNTER = 0xFFFFFFFE, EXPR = 1, start -> COUNTER wraps through 0xFFFFFFFF to 0, irq after 4 cycles.
REQ-033 SHALL cover: rst low during ACCESS -> no rdy_ pulse, all registers 0 next cycle.
